// File: rtl/eth_rx_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eth_rx_frame_ctrl - RMII receive sequencer: SFD hunt, CRC feed,       |
// | speculative frame buffer with commit/rollback, byte output stream.    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module eth_rx_frame_ctrl #(
  parameter int DEPTH      = 2048,
  parameter int MAX_FRAME  = 1522,
  parameter int MIN_FRAME  = 64,
  parameter int LEN_DEPTH  = 4,
  parameter int CK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        crsdv,
  input  logic [1:0]  rxd,
  output logic        ck_axiiv,
  output logic [1:0]  ck_axiid,
  input  logic        ck_done,
  input  logic        ck_kill,
  output logic        axiov,
  output logic [7:0]  axiod,
  output logic        axiolast,
  input  logic        axioready,
  output logic        frame_good,
  output logic        frame_bad,
  output logic [15:0] drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(LEN_DEPTH);
  localparam int TW = $clog2(CK_TIMEOUT + 1);
  localparam logic [AW:0]   PTR_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_FOUR = {{(AW-2){1'b0}}, 3'd4};
  localparam logic [LW:0]   LQ_ONE   = {{LW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_ONE   = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, WAIT_CK, RESOLVE} state_t;
  state_t state, state_nx;

  logic [3:0]    pre_cnt;
  logic [1:0]    phase;
  logic [5:0]    shreg;
  logic [15:0]   byte_cnt;
  logic          overrun;
  logic [TW-1:0] to_cnt;
  logic          kill;
  logic [AW:0]   wr_tmp, wr_com, rd_ptr;
  logic [LW:0]   lq_wr, lq_rd;
  logic [15:0]   out_cnt;
  logic [15:0]   head_len;
  logic [7:0]    mem   [DEPTH];
  logic [15:0]   len_q [LEN_DEPTH];

  logic buf_full, lq_full, lq_empty, byte_done, wr_en, drop, can_fetch, load, pop;

  assign buf_full  = (wr_tmp[AW] != rd_ptr[AW]) && (wr_tmp[AW-1:0] == rd_ptr[AW-1:0]);
  assign lq_full   = (lq_wr[LW] != lq_rd[LW]) && (lq_wr[LW-1:0] == lq_rd[LW-1:0]);
  assign lq_empty  = (lq_wr == lq_rd);
  assign byte_done = (state == PAYLOAD) && crsdv && (phase == 2'd3);
  assign wr_en     = byte_done && !overrun && !buf_full && (byte_cnt != 16'(MAX_FRAME));
  assign drop      = kill || overrun || (phase != 2'd0) || (byte_cnt < 16'(MIN_FRAME)) || lq_full;
  // The reader never runs past the head frame; the next frame starts after the pop.
  assign head_len  = len_q[lq_rd[LW-1:0]];
  assign can_fetch = !lq_empty && (rd_ptr != wr_com) && (out_cnt < head_len);
  assign load      = can_fetch && (!axiov || axioready);
  assign pop       = axiov && axioready && axiolast;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (crsdv && rxd == 2'b01) state_nx = PREAMBLE;
      PREAMBLE: begin
        if (!crsdv)                                 state_nx = IDLE;
        else if (rxd == 2'b11 && pre_cnt >= 4'd4)   state_nx = PAYLOAD;
        else if (rxd != 2'b01)                      state_nx = IDLE;
      end
      PAYLOAD:  if (!crsdv) state_nx = WAIT_CK;
      WAIT_CK:  if (ck_done || to_cnt == TW'(CK_TIMEOUT)) state_nx = RESOLVE;
      RESOLVE:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_tmp[AW-1:0]] <= {rxd, shreg};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_cnt    <= '0;
      phase      <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      overrun    <= 1'b0;
      to_cnt     <= '0;
      kill       <= 1'b0;
      wr_tmp     <= '0;
      wr_com     <= '0;
      rd_ptr     <= '0;
      lq_wr      <= '0;
      lq_rd      <= '0;
      out_cnt    <= '0;
      for (int i = 0; i < LEN_DEPTH; i++) len_q[i] <= '0;
      ck_axiiv   <= 1'b0;
      ck_axiid   <= '0;
      axiov      <= 1'b0;
      axiod      <= '0;
      axiolast   <= 1'b0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      drop_count <= '0;
    end else begin
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      ck_axiiv   <= (state == PAYLOAD) && crsdv;
      if ((state == PAYLOAD) && crsdv) ck_axiid <= rxd;

      case (state)
        IDLE: pre_cnt <= 4'd1;
        PREAMBLE: begin
          if (rxd == 2'b01 && pre_cnt != 4'd15) pre_cnt <= pre_cnt + 4'd1;
          phase    <= '0;
          byte_cnt <= '0;
          overrun  <= 1'b0;
        end
        PAYLOAD: begin
          to_cnt <= '0;
          if (crsdv) begin
            phase <= phase + 2'd1;
            shreg <= {rxd, shreg[5:2]};
            if (wr_en) begin
              wr_tmp   <= wr_tmp + PTR_ONE;
              byte_cnt <= byte_cnt + 16'd1;
            end else if (byte_done) begin
              overrun <= 1'b1;
            end
          end
        end
        WAIT_CK: begin
          to_cnt <= to_cnt + TO_ONE;
          if (ck_done)                         kill <= ck_kill;
          else if (to_cnt == TW'(CK_TIMEOUT)) kill <= 1'b1;
        end
        RESOLVE: begin
          if (drop) begin
            wr_tmp    <= wr_com;
            frame_bad <= 1'b1;
            if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          end else begin
            // Commit everything except the trailing FCS.
            wr_com                 <= wr_tmp - PTR_FOUR;
            wr_tmp                 <= wr_tmp - PTR_FOUR;
            len_q[lq_wr[LW-1:0]]   <= byte_cnt - 16'd4;
            lq_wr                  <= lq_wr + LQ_ONE;
            frame_good             <= 1'b1;
          end
        end
        default: ;
      endcase

      if (load) begin
        axiod    <= mem[rd_ptr[AW-1:0]];
        axiolast <= (out_cnt == head_len - 16'd1);
        axiov    <= 1'b1;
        rd_ptr   <= rd_ptr + PTR_ONE;
        out_cnt  <= out_cnt + 16'd1;
      end else if (axiov && axioready) begin
        axiov    <= 1'b0;
        axiolast <= 1'b0;
      end
      if (pop) begin
        lq_rd   <= lq_rd + LQ_ONE;
        out_cnt <= '0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_eth_rx_frame_ctrl.sv
`default_nettype none
// tb_eth_rx_frame_ctrl - directed RMII frames checked against hand-built byte streams.
module tb_eth_rx_frame_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        crsdv;
  logic [1:0]  rxd;
  logic        ck_axiiv;
  logic [1:0]  ck_axiid;
  logic        ck_done;
  logic        ck_kill;
  logic        axiov;
  logic [7:0]  axiod;
  logic        axiolast;
  logic        axioready;
  logic        frame_good;
  logic        frame_bad;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;
  int n_good = 0, n_bad = 0, n_ckv = 0, stall_err = 0;
  bit toggle = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_d = '0;
  logic       prev_l = 1'b0;
  logic [7:0] got_q[$], exp_q[$];
  bit         gotl_q[$], expl_q[$];

  eth_rx_frame_ctrl dut (
    .clk(clk), .rst(rst), .crsdv(crsdv), .rxd(rxd),
    .ck_axiiv(ck_axiiv), .ck_axiid(ck_axiid), .ck_done(ck_done), .ck_kill(ck_kill),
    .axiov(axiov), .axiod(axiod), .axiolast(axiolast), .axioready(axioready),
    .frame_good(frame_good), .frame_bad(frame_bad), .drop_count(drop_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!axiov || axiod != prev_d || axiolast != prev_l))
        stall_err <= stall_err + 1;
      prev_stall <= axiov && !axioready;
      prev_d     <= axiod;
      prev_l     <= axiolast;
      if (axiov && axioready) begin
        got_q.push_back(axiod);
        gotl_q.push_back(axiolast);
      end
    end
    if (frame_good) n_good <= n_good + 1;
    if (frame_bad)  n_bad  <= n_bad + 1;
    if (ck_axiiv)   n_ckv  <= n_ckv + 1;
  end

  initial begin
    axioready = 1'b1;
    forever begin
      @(posedge clk); #1;
      axioready = toggle ? ~axioready : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_dibit(input logic [1:0] d);
    step();
    crsdv = 1'b1;
    rxd   = d;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) drive_dibit(b[2*i +: 2]);
  endtask

  // n = frame bytes including FCS; payload byte k is base+k.
  task automatic send_frame(input int n, input logic [7:0] base, input bit respond,
                            input bit kill_v, input bit expect_out);
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int k = 0; k < n - 4; k++) begin
      drive_byte(base + 8'(k));
      if (expect_out) begin
        exp_q.push_back(base + 8'(k));
        expl_q.push_back(k == n - 5);
      end
    end
    for (int j = 0; j < 4; j++) drive_byte(8'hF0 + 8'(j));
    step();
    crsdv = 1'b0;
    rxd   = 2'b00;
    if (respond) begin
      repeat (3) step();
      ck_done = 1'b1;
      ck_kill = kill_v;
      step();
      ck_done = 1'b0;
      ck_kill = 1'b0;
    end
  endtask

  task automatic wait_drain(input int n, input int budget);
    int k = 0;
    while ((got_q.size() < n || axiov) && k < budget) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_stream(input string tag);
    int derr = 0;
    int lerr = 0;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i])   derr++;
      if (gotl_q[i] !== expl_q[i]) lerr++;
    end
    chk({tag, "_data_errs"}, derr, 0);
    chk({tag, "_last_errs"}, lerr, 0);
    got_q.delete(); gotl_q.delete(); exp_q.delete(); expl_q.delete();
  endtask

  initial begin
    rst = 1'b0; crsdv = 1'b0; rxd = 2'b00; ck_done = 1'b0; ck_kill = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_axiov", axiov, 0);
    chk("rst_axiod", axiod, 0);
    chk("rst_axiolast", axiolast, 0);
    chk("rst_ck_axiiv", ck_axiiv, 0);
    chk("rst_ck_axiid", ck_axiid, 0);
    chk("rst_good", frame_good, 0);
    chk("rst_bad", frame_bad, 0);
    chk("rst_drop", drop_count, 0);
    step(); rst = 1'b1;
    repeat (2) step();

    // Minimum-size good frame
    send_frame(64, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_drain(60, 500);
    check_stream("t1");
    chk("t1_good", n_good, 1);
    chk("t1_ckv", n_ckv, 256);
    chk("t1_drop", drop_count, 0);

    // CRC kill, then a clean frame must not carry stale bytes
    send_frame(64, 8'h00, 1'b1, 1'b1, 1'b0);
    wait_drain(0, 50);
    check_stream("t2k");
    chk("t2_bad", n_bad, 1);
    chk("t2_drop", drop_count, 1);
    send_frame(64, 8'h80, 1'b1, 1'b0, 1'b1);
    wait_drain(60, 500);
    check_stream("t2g");
    chk("t2_good", n_good, 2);

    // Short preamble: 3x01 then 11 must not lock
    for (int i = 0; i < 3; i++) drive_dibit(2'b01);
    drive_dibit(2'b11);
    for (int i = 0; i < 8; i++) drive_byte(8'h00);
    step(); crsdv = 1'b0; rxd = 2'b00;
    repeat (20) step();
    chk("t3_ckv", n_ckv, 768);
    chk("t3_drop", drop_count, 1);
    chk("t3_bad", n_bad, 1);
    chk("t3_out", got_q.size(), 0);

    // Checker silent: timeout drop
    send_frame(100, 8'h20, 1'b0, 1'b0, 1'b0);
    repeat (30) step();
    chk("t4_bad", n_bad, 2);
    chk("t4_drop", drop_count, 2);
    chk("t4_good", n_good, 2);
    chk("t4_out", got_q.size(), 0);

    // Back-to-back 64 and 1522 byte frames with ready toggling
    toggle = 1'b1;
    send_frame(64, 8'h10, 1'b1, 1'b0, 1'b1);
    send_frame(1522, 8'h33, 1'b1, 1'b0, 1'b1);
    wait_drain(1578, 10000);
    toggle = 1'b0;
    check_stream("t5");
    chk("t5_stall", stall_err, 0);
    chk("t5_good", n_good, 4);
    chk("t5_drop", drop_count, 2);

    // Reset mid-payload, then recover
    for (int i = 0; i < 7; i++) drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int k = 0; k < 20; k++) drive_byte(8'(k));
    step(); rst = 1'b0;
    step(); rst = 1'b1; crsdv = 1'b0; rxd = 2'b00;
    @(negedge clk);
    chk("t6_axiov", axiov, 0);
    chk("t6_ck_axiiv", ck_axiiv, 0);
    chk("t6_drop_rst", drop_count, 0);
    chk("t6_bad_rst", frame_bad, 0);
    repeat (2) step();
    send_frame(64, 8'h40, 1'b1, 1'b0, 1'b1);
    wait_drain(60, 500);
    check_stream("t6");
    chk("t6_good", n_good, 5);
    chk("t6_drop", drop_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
Receive-side sequencer for the RMII Ethernet path. It finds preamble/SFD on the 2-bit RMII stream and feeds frame dibits to the external CRC checker (the block that exposes axiiv/axiid inputs and done/kill outputs). It buffers frame bytes speculatively, then commits or rolls back each frame on the checker's verdict. Committed frames, with the FCS stripped, go to the game-packet parser on a byte stream with valid/ready/last.

Parameters:
DEPTH, 2048, frame buffer size in bytes; power of 2.
MAX_FRAME, 1522, maximum frame bytes including FCS.
MIN_FRAME, 64, minimum frame bytes including FCS.
LEN_DEPTH, 4, committed-frame length queue entries; power of 2.
CK_TIMEOUT, 16, cycles to wait for checker verdict.

Ports:
clk  in  1  system clock (50 MHz RMII ref clock).
rst  in  1  synchronous, active-low reset.
crsdv  in  1  RMII carrier sense / data valid.
rxd  in  2  RMII receive dibit, LSB-first.
ck_axiiv  out  1  dibit valid to CRC checker.
ck_axiid  out  2  dibit to CRC checker.
ck_done  in  1  checker verdict strobe.
ck_kill  in  1  checker CRC-fail flag, qualified by ck_done.
axiov  out  1  output byte valid.
axiod  out  8  output byte.
axiolast  out  1  last byte of frame.
axioready  in  1  downstream ready.
frame_good  out  1  one-cycle pulse per committed frame.
frame_bad  out  1  one-cycle pulse per dropped frame.
drop_count  out  16  dropped-frame counter, saturating.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs go to 0. ck_axiid=0, drop_count=0.
  - All pointers and the length queue are cleared. The state is IDLE.
  - Any in-flight or buffered frame is discarded.
- States: IDLE, PREAMBLE, PAYLOAD, WAIT_CK, RESOLVE.
- IDLE:
  - crsdv=1 and rxd=01 -> PREAMBLE; pre_cnt=1.
  - Anything else stays in IDLE.
- PREAMBLE:
  - rxd=01: pre_cnt++ (saturates at 15).
  - rxd=11 with pre_cnt>=4: SFD accepted -> PAYLOAD.
  - rxd=11 with pre_cnt<4, any other rxd, or crsdv=0 -> IDLE. No checker activity, no drop counted.
- PAYLOAD:
  - Each crsdv=1 cycle registers ck_axiiv=1 and ck_axiid=rxd. Checker latency is 1 cycle.
  - Dibits are packed LSB-first. Every 4th dibit writes a byte at wr_tmp, then wr_tmp++ (mod DEPTH) and byte_cnt++.
  - Overrun is set if byte_cnt would exceed MAX_FRAME or wr_tmp would reach rd_ptr (buffer full). After overrun, buffer writes stop but the checker is still fed.
  - crsdv=0 -> ck_axiiv=0 next cycle -> WAIT_CK; to_cnt=0.
- WAIT_CK:
  - to_cnt++ each cycle.
  - ck_done=1 -> RESOLVE, latching ck_kill.
  - to_cnt==CK_TIMEOUT -> RESOLVE with kill forced to 1.
- RESOLVE (1 cycle):
  - Drop if any of: kill, overrun, dibit count not a multiple of 4, byte_cnt<MIN_FRAME, or length queue full.
  - On drop: wr_tmp <= wr_com; frame_bad=1; drop_count++ (saturates at 0xFFFF).
  - On commit: wr_com <= wr_tmp-4 (FCS stripped); wr_tmp <= wr_tmp-4; push byte_cnt-4 into the length queue; frame_good=1.
  - Then -> IDLE. Back-to-back frames are accepted from IDLE on the next cycle.
- Output side runs independently of receive:
  - Buffer read is synchronous with registered output.
  - axiov=1 only while the length queue is non-empty and rd_ptr != wr_com.
  - When axiov=1 and axioready=0, axiod/axiolast hold stable.
  - A transfer occurs on axiov&&axioready. axiolast=1 on the final byte of the head length; that transfer pops the queue.
  - Sustained rate is 1 byte/cycle under continuous ready.
- Pointers are log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty.
- Simultaneous commit and output pop in one cycle: both occur; queue occupancy is unchanged.
- ck_done outside WAIT_CK is ignored.

Test Plan:
- 7×0x55, 0xD5, 60 payload bytes 0x00..0x3B, 4 FCS bytes; checker ck_done=1/ck_kill=0 -> 60 bytes out 0x00..0x3B, axiolast on 0x3B, frame_good pulse, drop_count=0.
- Same frame with ck_kill=1 -> no axiov, frame_bad pulse, drop_count=1. A following good frame is output intact with no stale bytes.
- Preamble of only 3 dibits of 01 followed by 11 -> stays IDLE, ck_axiiv never asserts, drop_count unchanged.
- Good 100-byte frame, no ck_done -> after 16 cycles in WAIT_CK, frame_bad pulse, drop_count increments.
- Two back-to-back good frames (64 and 1522 bytes) with axioready toggled 1/0 every cycle -> 60 then 1518 bytes in order, axiod stable while stalled, two axiolast.
- rst=0 for one cycle mid-PAYLOAD -> all outputs 0, state IDLE, next valid frame received and output correctly.
